// File: rtl/mult_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_ctrl_if
//  Description : Request/result bundle for the sequential multiplier.
//                The master issues start with operands a/b. The slave returns
//                busy, a one-cycle done strobe and the held product p.
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );
endinterface
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_ctrl
//  Description : Shift-and-add unsigned multiplier with its own control FSM.
//                It consumes one multiplier bit per clock and produces the
//                2*WIDTH-bit product with a one-cycle done strobe. A zero
//                operand skips the iteration phase entirely.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_seq_ctrl_if.slave bus
);
    // Counter only needs to reach WIDTH-1 (WIDTH >= 2 keeps this width >= 1).
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_p;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_zero;

    // Partial-product step. The 2*WIDTH accumulator cannot overflow because
    // (2^W-1)^2 < 2^(2W).
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_zero     = (bus.a == '0) || (bus.b == '0);

    assign bus.busy = (r_state == c_RUN);
    assign bus.done = (r_state == c_DONE);
    assign bus.p    = r_p;

    // Control FSM and datapath. p only moves on the edge that enters DONE,
    // so it is valid in the done cycle and holds until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (w_zero) begin
                            // Product is trivially zero: skip RUN.
                            r_mcand  <= '0;
                            r_mplier <= '0;
                            r_p      <= '0;
                            r_state  <= c_DONE;
                        end else begin
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                            r_state  <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_p     <= w_acc_next;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq_ctrl
//  Description : Self-checking bench for mult_seq_ctrl (WIDTH=8). Expected
//                products and done latencies come from plain arithmetic on
//                the operands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_seq_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   last_done_cyc;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to measure done-to-done spacing.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: product is a*b; done arrives one cycle after the start edge
    // for a zero operand, otherwise WIDTH+1 cycles after it.
    function automatic logic [2*W-1:0] ref_p(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [31:0] prod;
        prod = 32'(x) * 32'(y);
        return prod[2*W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x == 0 || y == 0) ? 1 : W + 1;
    endfunction

    // Present a one-cycle start; returns in the cycle after the start edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Wait for done (bounded), then check latency, busy span, product,
    // busy/done exclusivity and that done is a single-cycle pulse.
    task automatic wait_done(input string tag, input logic [2*W-1:0] exp_p,
                             input int lat0, input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        lat  = lat0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        last_done_cyc = cyc;
        chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
        chk({tag, "_p"},    32'(bus.p), 32'(exp_p));
        chk({tag, "_excl"}, 32'(bus.busy & bus.done), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        lat = ref_lat(x, y);
        launch(x, y);
        wait_done(tag, ref_p(x, y), 1, lat, lat - 1);
    endtask

    initial begin
        int first_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total = 0;
        bad   = 0;
        last_done_cyc = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_p",    32'(bus.p),    32'd0);
        rst_n = 1'b1;

        // Basic product and hold
        op("13x11", 8'd13, 8'd11);
        repeat (10) @(negedge clk);
        chk("hold_p", 32'(bus.p), 32'd143);
        chk("hold_done", 32'(bus.done), 32'd0);

        op("255x255", 8'd255, 8'd255);
        op("128x2",   8'd128, 8'd2);

        // Zero shortcut
        op("0x55",  8'd0,   8'd55);
        op("200x0", 8'd200, 8'd0);

        // Start pulse in RUN cycle 4 is ignored
        launch(8'd7, 8'd9);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd3;
        bus.b     = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore", 16'd63, 5, W + 1, W - 4);

        // Start held high across two operations
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd6;
        bus.b     = 8'd7;
        @(negedge clk);
        bus.a     = 8'd5;
        bus.b     = 8'd5;
        wait_done("held1", 16'd42, 1, W + 1, W);
        first_done = last_done_cyc;
        wait_done("held2", 16'd25, 0, W + 1, W);
        chk("held_spacing", 32'(last_done_cyc - first_done), 32'(W + 2));
        bus.start = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-RUN
        launch(8'd100, 8'd100);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_p",    32'(bus.p),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            end
            chk("post_rst_idle", 32'(seen), 32'd0);
        end
        op("2x3", 8'd2, 8'd3);

        // Randomized sweep with corner operands mixed in
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 8'd0;
                1: ra = 8'd1;
                2: ra = 8'hFF;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rb = 8'd0;
                1: rb = 8'd1;
                2: rb = 8'hFF;
                default: rb = W'($urandom);
            endcase
            op("rand", ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequential shift-and-add multiplier with its own control FSM. It is the multi-cycle, area-reduced counterpart to the team's combinational multiplier.
- Accepts a start pulse with two unsigned WIDTH-bit operands. Iterates one multiplier bit per clock.
- Reports the 2*WIDTH-bit product with a one-cycle done pulse.
- Sits between a requesting controller (start/busy/done) and downstream logic that samples the product.

Parameters:
- WIDTH, 8, operand width in bits (legal 2..16). The product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, unsigned; sampled with start.
- b  input  WIDTH  multiplier, unsigned; sampled with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; high while state is DONE.
- p  output  2*WIDTH  product register; holds its last value until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, p=0, internal operand and accumulator registers=0, iteration counter=0.
- States:
  - IDLE: wait for start.
  - RUN: one iteration per cycle.
  - DONE: one-cycle result strobe, then return to IDLE.
- Transitions:
  - IDLE & start & (a==0 | b==0) -> DONE. Accumulator loaded with 0; p=0 on the following cycle (zero shortcut, no RUN cycles).
  - IDLE & start & a!=0 & b!=0 -> RUN. Load mcand={WIDTH zeros, a}, mplier=b, acc=0, cnt=0.
  - IDLE & !start -> IDLE.
  - RUN, each cycle:
    - if mplier[0], acc <= acc + mcand; mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
    - when cnt==WIDTH-1, the update is applied and the next state is DONE.
  - DONE -> IDLE unconditionally.
- Accumulation is in 2*WIDTH bits and never overflows, since max (2^W-1)^2 < 2^(2W).
- Output update and timing:
  - p <= final acc on the edge entering DONE, so p is valid in the same cycle done=1.
  - done is registered, equal to (state==DONE); busy equals (state==RUN).
- Latency:
  - Start sampled at edge E0: RUN during edges E1..E(WIDTH); done high in the cycle after edge E(WIDTH). That is WIDTH+1 cycles from start-sample to done (including the DONE-entry edge).
  - Zero shortcut: done high in the cycle after E0.
- Boundary rules:
  - start asserted during RUN or DONE is ignored. It is not queued, and a/b are not sampled.
  - A new start may be accepted in the cycle immediately after DONE (IDLE). Back-to-back throughput is one result per WIDTH+2 cycles.
  - a and b may change freely after the sampling edge without affecting the result.
  - rst_n low mid-RUN aborts the operation: all outputs return to reset values at once, and there is no done pulse.
  - rst_n release then needs a fresh start.
  - start held high continuously: each new operation begins at the IDLE cycle following DONE.

Test Plan:
- WIDTH=8, a=13, b=11, 1-cycle start -> busy high 8 cycles; done pulses once, 9 cycles after the start edge; p=143; p still 143 ten cycles later.
- a=255, b=255 -> p=65025 (16'hFE01), no overflow. Also a=128, b=2 -> p=256.
- a=0, b=55 -> done in the cycle after start, p=0, busy never asserted. Repeat with a=200, b=0 -> p=0.
- Start a=7, b=9. Pulse start with a=3, b=3 at RUN cycle 4 -> ignored, p=63. Start held high across two ops (6x7, then 5x5 presented after done) -> p=42 then p=25, each separated by WIDTH+2 cycles.
- Start a=100, b=100, drive rst_n=0 asynchronously at RUN cycle 3 -> busy=0, done=0, p=0 immediately. After release, with no start, the block stays IDLE with no done. Then start 2x3 -> p=6.
- Randomized sweep, 500 operand pairs (including 0, 1, 2^W-1): p equals a*b, exactly one done per accepted start, busy and done never high together.
